// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame serializer.
package dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD1 = 3'd4
    } state_t;

    localparam logic [3:0] CMD_WR_UPD = 4'b0011;
    localparam logic [3:0] ADDR_CH0   = 4'd0;
    localparam logic [3:0] ADDR_CH1   = 4'd1;

    function automatic int frame_width(input int m);
        return m + 8;
    endfunction

endpackage

// File: rtl/dac_spi_shift.sv
// Mode-0 SPI shifter for one frame: sclk divider, half-period counter,
// MSB-first data launched on falling edges, done on the last cycle.
module dac_spi_shift #(
    parameter int W       = 24,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] frame,
    output logic         sclk,
    output logic         mosi,
    output logic         done
);

    // 24 low/high pairs plus the trailing low half before cs_n rises
    localparam int HALVES = 2 * W + 1;
    localparam int HW     = $clog2(HALVES + 1);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          running;
    logic [W-1:0]  sh;
    logic [DW-1:0] div;
    logic [HW-1:0] half;
    logic [HW-1:0] half_nx;
    logic          div_end;

    assign half_nx = half + HW'(1);
    assign div_end = (div == DW'(CLK_DIV - 1));
    assign done    = running && div_end && (half == HW'(HALVES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            sh      <= '0;
            div     <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (load) begin
            running <= 1'b1;
            sh      <= frame;
            div     <= '0;
            half    <= '0;
            sclk    <= 1'b0;
            mosi    <= frame[W-1];
        end else if (done) begin
            running <= 1'b0;
            div     <= '0;
            half    <= '0;
        end else if (running) begin
            if (div_end) begin
                div  <= '0;
                half <= half_nx;
                sclk <= half_nx[0];
                // even half index = falling edge: launch next bit
                if (!half_nx[0]) begin
                    mosi <= sh[W-2];
                    sh   <= {sh[W-2:0], 1'b0};
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/dac_frame_serializer.sv
// Attenuates signed sample pairs, converts to offset binary and sends
// each channel as a write-and-update SPI frame to a dual-channel DAC.
module dac_frame_serializer
    import dac_pkg::*;
#(
    parameter int M       = 16,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [M-1:0] ch0,
    input  logic [M-1:0] ch1,
    input  logic         dual,
    input  logic [3:0]   atten,
    output logic         sclk,
    output logic         mosi,
    output logic         cs_n,
    output logic         busy,
    output logic         frame_done,
    output logic [15:0]  drop_count
);

    localparam int W  = frame_width(M);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    function automatic logic [W-1:0] build_frame(
        input logic [3:0]   addr,
        input logic [M-1:0] ch,
        input logic [3:0]   sh
    );
        logic signed [M-1:0] s;
        s = $signed(ch) >>> sh;
        return {CMD_WR_UPD, addr, ~s[M-1], s[M-2:0]};
    endfunction

    state_t        state;
    state_t        next;
    logic          slot_full;
    logic [M-1:0]  slot_ch0;
    logic [M-1:0]  slot_ch1;
    logic          slot_dual;
    logic [3:0]    slot_atten;
    logic [W-1:0]  frame1;
    logic          owe1;
    logic [GW-1:0] gap_cnt;
    logic          gap_last;
    logic          pending;
    logic          consume;
    logic          load;
    logic          sh_done;
    logic [W-1:0]  load_frame;

    // a strobe in this cycle counts as pending so IDLE leaves immediately
    assign pending    = slot_full || sample_valid;
    assign consume    = (state == ST_LOAD);
    assign load       = consume || (state == ST_LOAD1);
    assign gap_last   = (gap_cnt == GW'(CS_GAP - 1));
    assign load_frame = consume
                      ? build_frame(ADDR_CH0, slot_ch0, slot_atten)
                      : frame1;

    always_comb begin
        next = state;
        unique case (state)
            ST_IDLE:  if (pending) next = ST_LOAD;
            ST_LOAD:  next = ST_SHIFT;
            ST_LOAD1: next = ST_SHIFT;
            ST_SHIFT: if (sh_done) next = ST_GAP;
            ST_GAP: begin
                if (gap_last) begin
                    if (owe1)         next = ST_LOAD1;
                    else if (pending) next = ST_LOAD;
                    else              next = ST_IDLE;
                end
            end
            default:  next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cs_n       <= 1'b1;
            gap_cnt    <= '0;
            frame1     <= '0;
            owe1       <= 1'b0;
        end else begin
            state      <= next;
            busy       <= (next != ST_IDLE);
            frame_done <= sh_done;
            if (load)         cs_n <= 1'b0;
            else if (sh_done) cs_n <= 1'b1;
            if (state == ST_GAP && !gap_last) gap_cnt <= gap_cnt + GW'(1);
            else                              gap_cnt <= '0;
            if (consume) begin
                frame1 <= build_frame(ADDR_CH1, slot_ch1, slot_atten);
                owe1   <= slot_dual;
            end else if (state == ST_LOAD1) begin
                owe1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full  <= 1'b0;
            slot_ch0   <= '0;
            slot_ch1   <= '0;
            slot_dual  <= 1'b0;
            slot_atten <= '0;
            drop_count <= '0;
        end else begin
            slot_full <= sample_valid || (slot_full && !consume);
            if (sample_valid) begin
                slot_ch0   <= ch0;
                slot_ch1   <= ch1;
                slot_dual  <= dual;
                slot_atten <= atten;
            end
            if (sample_valid && slot_full && !consume
                && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    dac_spi_shift #(
        .W       (W),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .frame (load_frame),
        .sclk  (sclk),
        .mosi  (mosi),
        .done  (sh_done)
    );

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Scoreboard bench: SPI decoder monitor against an arithmetic frame model.
module tb_dac_frame_serializer;

    localparam int M       = 16;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] ch0 = '0;
    logic [15:0] ch1 = '0;
    logic        dual = 1'b0;
    logic [3:0]  atten = '0;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        busy;
    logic        frame_done;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    dac_frame_serializer #(
        .M       (M),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .ch0          (ch0),
        .ch1          (ch1),
        .dual         (dual),
        .atten        (atten),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .busy         (busy),
        .frame_done   (frame_done),
        .drop_count   (drop_count)
    );

    int          tests = 0;
    int          fails = 0;
    logic [23:0] exp_q[$];
    int          nf = 0;
    int          starts = 0;
    bit          sb_on = 1'b1;
    int          last_high_len = 0;
    int          exp_drop = 0;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endfunction

    // floor(ch / 2^a) then offset by half scale
    function automatic logic [23:0] model(input int addr,
                                          input logic [15:0] raw,
                                          input int a);
        int s, d, q;
        s = int'(raw);
        if (s >= 32768) s -= 65536;
        d = 1 << a;
        q = s / d;
        if (s < 0 && q * d != s) q -= 1;
        return {4'h3, 4'(addr), 16'(q + 32768)};
    endfunction

    // SPI monitor
    bit          prev_cs = 1'b1;
    bit          prev_sclk = 1'b0;
    bit          prev_mosi = 1'b0;
    bit          in_frame = 1'b0;
    bit          mosi_ok = 1'b1;
    int          nbits = 0;
    int          low_len = 0;
    int          hi_len = 0;
    logic [23:0] word = '0;
    logic [23:0] expw;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
            nbits    = 0;
            hi_len   = 0;
        end else begin
            if (prev_cs && !cs_n) begin
                starts++;
                last_high_len = hi_len;
                in_frame = 1'b1;
                nbits    = 0;
                low_len  = 0;
                word     = '0;
                mosi_ok  = 1'b1;
            end
            if (!cs_n) begin
                low_len++;
                if (!prev_sclk && sclk) begin
                    word = {word[22:0], mosi};
                    nbits++;
                end
                if (!prev_cs && mosi != prev_mosi
                    && !(prev_sclk && !sclk))
                    mosi_ok = 1'b0;
            end
            if (!prev_cs && cs_n && in_frame) begin
                in_frame = 1'b0;
                hi_len   = 0;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL frame_unexpected: got %h expected none",
                                 word);
                    end else begin
                        expw = exp_q.pop_front();
                        check("frame_word", 32'(word), 32'(expw));
                    end
                    check("frame_bits", nbits, 24);
                    check("frame_cs_low", low_len, 49 * CLK_DIV);
                    check("frame_done_pulse", 32'(frame_done), 1);
                    check("mosi_stable", 32'(mosi_ok), 1);
                end
            end
            if (cs_n) hi_len++;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a0, input logic [15:0] a1,
                            input logic d, input logic [3:0] at);
        exp_q.push_back(model(0, a0, int'(at)));
        nf++;
        if (d) begin
            exp_q.push_back(model(1, a1, int'(at)));
            nf++;
        end
    endtask

    task automatic strobe(input logic [15:0] a0, input logic [15:0] a1,
                          input logic d, input logic [3:0] at);
        ch0 = a0;
        ch1 = a1;
        dual = d;
        atten = at;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!busy && exp_q.size() == 0) return;
        end
        timeout(name);
    endtask

    task automatic wait_cs_low(input string name);
        for (int i = 0; i < 500; i++) begin
            if (!cs_n) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 500; i++) begin
            if (frame_done) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_started(input int idx);
        for (int i = 0; i < 3000; i++) begin
            if (starts > idx) return;
            tick();
        end
        timeout("consume_wait");
    endtask

    logic [15:0] tab_ch[6] = '{16'h0000, 16'h8000, 16'h7FFF,
                               16'h8001, 16'h7FFF, 16'h1234};
    logic [3:0]  tab_at[6] = '{4'd0, 4'd0, 4'd4, 4'd15, 4'd15, 4'd3};

    initial begin
        logic [15:0] r0, r1;
        logic        rd;
        logic [3:0]  ra;
        int          last_idx;

        repeat (3) tick();
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_drop", 32'(drop_count), 0);
        rst = 1'b1;
        repeat (2) tick();

        // latency of the first frame from an idle strobe
        push_exp(16'h0000, 16'h0000, 1'b0, 4'd0);
        strobe(16'h0000, 16'h0000, 1'b0, 4'd0);
        check("load_busy", 32'(busy), 1);
        check("load_cs_n", 32'(cs_n), 1);
        tick();
        check("start_cs_n", 32'(cs_n), 0);
        check("start_mosi", 32'(mosi), 0);
        wait_idle("idle_first");

        for (int i = 1; i < 6; i++) begin
            push_exp(tab_ch[i], 16'h0000, 1'b0, tab_at[i]);
            strobe(tab_ch[i], 16'h0000, 1'b0, tab_at[i]);
            wait_idle("idle_table");
        end

        push_exp(16'h0001, 16'hFFFF, 1'b1, 4'd0);
        strobe(16'h0001, 16'hFFFF, 1'b1, 4'd0);
        wait_idle("idle_dual");
        check("dual_gap", last_high_len, CS_GAP + 1);

        // overwrite: only the last of three busy-time strobes survives
        push_exp(16'h1111, 16'h0000, 1'b0, 4'd0);
        strobe(16'h1111, 16'h0000, 1'b0, 4'd0);
        wait_cs_low("cs_low_drop");
        strobe(16'h2222, 16'h0000, 1'b0, 4'd1);
        strobe(16'h3333, 16'h0000, 1'b0, 4'd2);
        push_exp(16'hC444, 16'h0000, 1'b0, 4'd3);
        strobe(16'hC444, 16'h0000, 1'b0, 4'd3);
        exp_drop += 2;
        wait_idle("idle_drop");
        check("drop_three", 32'(drop_count), 32'(exp_drop));

        // strobe lands in the LOAD cycle that consumes the slot
        push_exp(16'h0F0F, 16'h0000, 1'b0, 4'd0);
        strobe(16'h0F0F, 16'h0000, 1'b0, 4'd0);
        wait_cs_low("cs_low_gap");
        push_exp(16'hF0F0, 16'h0000, 1'b0, 4'd1);
        strobe(16'hF0F0, 16'h0000, 1'b0, 4'd1);
        wait_done("done_gap");
        repeat (CS_GAP) tick();
        push_exp(16'h5A5A, 16'h0000, 1'b0, 4'd2);
        strobe(16'h5A5A, 16'h0000, 1'b0, 4'd2);
        wait_idle("idle_gap");
        check("gap_no_drop", 32'(drop_count), 32'(exp_drop));
        check("gap_b2b", last_high_len, CS_GAP + 1);

        // asynchronous reset in the middle of a frame
        push_exp(16'hFFFF, 16'h0000, 1'b0, 4'd0);
        strobe(16'hFFFF, 16'h0000, 1'b0, 4'd0);
        wait_cs_low("cs_low_rst");
        repeat (21) tick();
        rst = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        #1;
        check("mid_rst_cs_n", 32'(cs_n), 1);
        check("mid_rst_sclk", 32'(sclk), 0);
        check("mid_rst_mosi", 32'(mosi), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_drop", 32'(drop_count), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        push_exp(16'h7FFF, 16'h0000, 1'b0, 4'd0);
        strobe(16'h7FFF, 16'h0000, 1'b0, 4'd0);
        wait_idle("idle_rst");

        last_idx = -1;
        for (int k = 0; k < 30; k++) begin
            if (last_idx >= 0) wait_started(last_idx);
            repeat ($urandom_range(0, 60)) tick();
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            rd = 1'($urandom);
            ra = 4'($urandom_range(0, 15));
            last_idx = nf;
            push_exp(r0, r1, rd, ra);
            strobe(r0, r1, rd, ra);
        end
        wait_idle("idle_random");
        check("random_no_drop", 32'(drop_count), 32'(exp_drop));

        // saturating overrun counter
        sb_on = 1'b0;
        ch0 = 16'h0BAD;
        dual = 1'b1;
        sample_valid = 1'b1;
        repeat (68000) tick();
        sample_valid = 1'b0;
        wait_idle("idle_sat");
        check("drop_saturate", 32'(drop_count), 32'hFFFF);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
